// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, fixed XLEN+2 cycle latency for every operation.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            flush,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [6:0]        OPCODE_REG    = 7'b0110011;
  localparam logic [6:0]        FUNCT7_MULDIV = 7'b0000001;
  localparam logic [XLEN-1:0]   ONE           = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_W         = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_LAST      = CW'(XLEN - 1);
  localparam logic [CW-1:0]     CNT_ONE       = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    neg_x = ~v + ONE;
  endfunction

  state_t            state_r;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_mag_r, b_mag_r, hi_r, lo_r;
  logic              sa_r, sb_r, b_zero_r;
  logic [CW-1:0]     count_r;

  logic              accept_s, a_signed_s, b_signed_s, sa_s, sb_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [XLEN:0]     sum_s, shifted_s;
  logic              ge_s;
  logic [XLEN-1:0]   diff_s, hi_next_s, lo_next_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, fix_res_s;

  // Request qualification and operand sign/magnitude split
  always_comb begin
    accept_s = (state_r == IDLE) && start && !flush &&
               (opcode == OPCODE_REG) && (funct7 == FUNCT7_MULDIV);
    case (funct3)
      3'b001:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      3'b010:  begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      3'b100:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      3'b110:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    sa_s    = a_signed_s & a[XLEN-1];
    sb_s    = b_signed_s & b[XLEN-1];
    a_mag_s = sa_s ? neg_x(a) : a;
    b_mag_s = sb_s ? neg_x(b) : b;
  end

  // One radix-2 step: {hi,lo} holds product (multiply) or remainder/quotient (divide)
  always_comb begin
    sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
    shifted_s = {hi_r, lo_r[XLEN-1]};
    ge_s      = shifted_s >= {1'b0, b_mag_r};
    diff_s    = shifted_s[XLEN-1:0] - b_mag_r;
    if (op_r[2]) begin
      hi_next_s = ge_s ? diff_s : shifted_s[XLEN-1:0];
      lo_next_s = {lo_r[XLEN-2:0], ge_s};
    end else begin
      hi_next_s = sum_s[XLEN:1];
      lo_next_s = {sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Sign correction and result selection; a zero divisor leaves |a| in hi, so REM yields a
  always_comb begin
    prod_s     = {hi_r, lo_r};
    prod_fix_s = (sa_r ^ sb_r) ? (~prod_s + ONE_W) : prod_s;
    quo_fix_s  = b_zero_r ? {XLEN{1'b1}} : ((sa_r ^ sb_r) ? neg_x(lo_r) : lo_r);
    rem_fix_s  = sa_r ? neg_x(hi_r) : hi_r;
    case (op_r)
      3'b000:  fix_res_s = prod_fix_s[XLEN-1:0];
      3'b001:  fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b010:  fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b011:  fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100:  fix_res_s = quo_fix_s;
      3'b101:  fix_res_s = quo_fix_s;
      3'b110:  fix_res_s = rem_fix_s;
      3'b111:  fix_res_s = rem_fix_s;
      default: fix_res_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= {XLEN{1'b0}};
      op_r     <= 3'b000;
      a_mag_r  <= {XLEN{1'b0}};
      b_mag_r  <= {XLEN{1'b0}};
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      b_zero_r <= 1'b0;
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            state_r  <= CALC;
            busy     <= 1'b1;
            op_r     <= funct3;
            a_mag_r  <= a_mag_s;
            b_mag_r  <= b_mag_s;
            sa_r     <= sa_s;
            sb_r     <= sb_s;
            b_zero_r <= (b == {XLEN{1'b0}});
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= funct3[2] ? a_mag_s : b_mag_s;
            count_r  <= CNT_LAST;
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          hi_r <= hi_next_s;
          lo_r <= lo_next_s;
          if (count_r == {CW{1'b0}}) begin
            state_r <= FIX;
          end else begin
            count_r <= count_r - CNT_ONE;
          end
        end
        FIX: begin
          result  <= fix_res_s;
          done    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vector table, reset
// sequence and randomized operations checked against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, flush;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .flush(flush),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [6:0]  f7;
    int          inj;
    int          fl;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the RISC-V M-extension definitions
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, p;
    logic [63:0] up;
    logic ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    model = 32'h0;
    case (op)
      3'd0: begin up = {32'h0, x} * {32'h0, y}; model = up[31:0]; end
      3'd1: begin p = sx * sy; model = p[63:32]; end
      3'd2: begin p = sx * $signed({32'h0, y}); model = p[63:32]; end
      3'd3: begin up = {32'h0, x} * {32'h0, y}; model = up[63:32]; end
      3'd4: begin
        if (y == 32'h0) model = 32'hFFFF_FFFF;
        else if (ovf) model = x;
        else begin p = sx / sy; model = p[31:0]; end
      end
      3'd5: model = (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'h0) model = x;
        else if (ovf) model = 32'h0;
        else begin p = sx % sy; model = p[31:0]; end
      end
      default: model = (y == 32'h0) ? x : x % y;
    endcase
  endfunction

  // Drives one request in the current cycle T and observes cycles T+1..T+35.
  // inj: cycle at which a second request is driven; fl: flush cycle (0 = with start, -1 = none).
  task automatic do_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [6:0] f7, input int inj, input int fl,
                       input logic [31:0] exp, input string name);
    int busy_cnt, done_cnt, done_at, early;
    bit acc, fin;
    logic [31:0] want;
    acc = (f7 == 7'b0000001) && (fl != 0);
    fin = acc && (fl < 0);
    busy_cnt = 0; done_cnt = 0; done_at = 0; early = 0;
    start = 1'b1; flush = (fl == 0); opcode = 7'b0110011;
    funct3 = op; funct7 = f7; a = va; b = vb;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k < 34 && result !== last_res) early++;
      start = (k == inj);
      flush = (k == fl);
      if (k == inj) begin
        funct3 = 3'b000; funct7 = 7'b0000001; a = 32'h1234_5678; b = 32'h0000_0003;
      end
    end
    start = 1'b0; flush = 1'b0;
    want = fin ? exp : last_res;
    check({name, " busy_cycles"}, busy_cnt, acc ? ((fl > 0) ? fl : 34) : 0);
    check({name, " done_cycle"}, done_at, fin ? 34 : 0);
    check({name, " done_pulses"}, done_cnt, fin ? 1 : 0);
    check({name, " result_early_change"}, early, 0);
    check({name, " result"}, result, want);
    last_res = want;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 7'b0000001, -1, -1, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 7'b0000001, -1, -1, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'b0000001, -1, -1, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'b0000001, -1, -1, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 7'b0000001, -1, -1, 32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 7'b0000001, -1, -1, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 7'b0000001, -1, -1, 32'hFFFF_FFFF};
    vecs[7]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 7'b0000001, -1, -1, 32'h0000_0005};
    vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 7'b0000001, -1, -1, 32'h8000_0000};
    vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 7'b0000001, -1, -1, 32'h0000_0000};
    vecs[10] = '{3'd0, 32'h0000_0009, 32'h0000_0009, 7'b0000000, -1, -1, 32'h0000_0051};
    vecs[11] = '{3'd0, 32'h0000_0064, 32'h0000_0003, 7'b0000001,  5, -1, 32'h0000_012C};
    vecs[12] = '{3'd5, 32'h0000_0064, 32'h0000_0007, 7'b0000001, 34, -1, 32'h0000_000E};
    vecs[13] = '{3'd0, 32'h0000_AAAA, 32'h0000_0003, 7'b0000001, -1, 10, 32'h0001_FFFE};
    vecs[14] = '{3'd4, 32'h0000_0014, 32'h0000_0004, 7'b0000001, -1,  0, 32'h0000_0005};

    rstn = 1'b0; start = 1'b0; flush = 1'b0; opcode = 7'h0;
    funct3 = 3'h0; funct7 = 7'h0; a = 32'h0; b = 32'h0;
    last_res = 32'h0;
    #2;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < 15; i++)
      do_op(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].f7, vecs[i].inj, vecs[i].fl,
            vecs[i].exp, $sformatf("vec%0d", i));

    // Reset mid-CALC: outputs must clear without waiting for a clock edge
    start = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000001;
    a = 32'h0000_0005; b = 32'h0000_0006;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_done", {31'h0, done}, 32'h0);
    check("midreset_result", result, 32'h0);
    last_res = 32'h0;
    @(posedge clk); #1;
    rstn = 1'b1;
    do_op(3'b000, 32'h3, 32'h4, 7'b0000001, -1, -1, 32'hC, "after_reset_mul");

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = rb & 32'h0000_00FF;
      else if (sel == 3) ra = ra & 32'h0000_FFFF;
      do_op(rop, ra, rb, 7'b0000001, -1, -1, model(rop, ra, rb), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
